latch_bank_snap: RTL and testbench

- Parametrised successor to the single-bit critical-section D latch.
- CHANNELS independent WIDTH-bit clocked holding registers. Each channel loads while its crit bit is high and holds while it is low.
- Adds per-channel sticky change flags and an atomic snapshot port with a valid/ready handshake, so a downstream consumer can read all channels coherently.
- Sits between producer logic and the spider control/readout path.

---
 rtl/latch_bank_snap.sv | 116 +++++++++++
 tb/tb_latch_bank_snap.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_snap.sv
// Bank of per-channel holding registers with sticky change flags and a valid/ready snapshot port.
// Optional macro LATCH_BANK_TRANSPARENT_EN makes dataOut combinationally transparent while crit is high.
module latch_bank_snap #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] dataIn,
  input  logic [CHANNELS-1:0]       crit,
  output logic [CHANNELS*WIDTH-1:0] dataOut,
  output logic [CHANNELS-1:0]       changed,
  input  logic                      snapReq,
  output logic                      snapValid,
  input  logic                      snapReady,
  output logic [CHANNELS*WIDTH-1:0] snapData,
  output logic [CHANNELS-1:0]       snapChanged,
  output logic                      snapDrop
);

  typedef enum logic {IDLE, VALID} state_t;

  state_t                    r_state;
  logic [CHANNELS*WIDTH-1:0] r_data;
  logic [CHANNELS*WIDTH-1:0] r_snapData;
  logic [CHANNELS-1:0]       r_changed;
  logic [CHANNELS-1:0]       r_snapChanged;
  logic                      r_snapValid;
  logic                      r_snapDrop;
  logic [CHANNELS-1:0]       w_loadDiff;
  logic                      w_capture;

  always_comb begin
    w_loadDiff = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_loadDiff[i] = crit[i] && (dataIn[i*WIDTH +: WIDTH] != r_data[i*WIDTH +: WIDTH]);
    end
  end

  // A new snapshot is taken from IDLE, or from VALID when the old one is accepted in the same cycle.
  assign w_capture = snapReq && ((r_state == IDLE) || snapReady);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (crit[i]) begin
          r_data[i*WIDTH +: WIDTH] <= dataIn[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Clearing on capture is OR-ed with new differences so a same-cycle change is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= '0;
    end else begin
      r_changed <= (w_capture ? '0 : r_changed) | w_loadDiff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_snapValid   <= 1'b0;
      r_snapData    <= '0;
      r_snapChanged <= '0;
      r_snapDrop    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (snapReq) begin
            r_state       <= VALID;
            r_snapValid   <= 1'b1;
            r_snapData    <= r_data;
            r_snapChanged <= r_changed;
          end
        end
        VALID: begin
          if (snapReady) begin
            if (snapReq) begin
              r_snapData    <= r_data;
              r_snapChanged <= r_changed;
            end else begin
              r_state     <= IDLE;
              r_snapValid <= 1'b0;
            end
          end else if (snapReq) begin
            r_snapDrop <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_snapValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LATCH_BANK_TRANSPARENT_EN
  for (genvar g = 0; g < CHANNELS; g++) begin : gen_transparent
    assign dataOut[g*WIDTH +: WIDTH] = crit[g] ? dataIn[g*WIDTH +: WIDTH] : r_data[g*WIDTH +: WIDTH];
  end
`else
  assign dataOut = r_data;
`endif

  assign changed     = r_changed;
  assign snapValid   = r_snapValid;
  assign snapData    = r_snapData;
  assign snapChanged = r_snapChanged;
  assign snapDrop    = r_snapDrop;

endmodule

// File: tb/tb_latch_bank_snap.sv
// Self-checking bench for latch_bank_snap: directed scenarios plus randomized traffic
// compared against an array-based reference model of channels and snapshot.
module tb_latch_bank_snap;

  localparam int W  = 8;
  localparam int CH = 4;

  logic            clk;
  logic            rst_n;
  logic [CH*W-1:0] dataIn;
  logic [CH-1:0]   crit;
  logic [CH*W-1:0] dataOut;
  logic [CH-1:0]   changed;
  logic            snapReq;
  logic            snapValid;
  logic            snapReady;
  logic [CH*W-1:0] snapData;
  logic [CH-1:0]   snapChanged;
  logic            snapDrop;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] mReg    [CH];
  logic         mChg    [CH];
  logic [W-1:0] mSnap   [CH];
  logic         mSnapCh [CH];
  logic         mValid;
  logic         mDrop;

  latch_bank_snap #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .crit(crit), .dataOut(dataOut),
    .changed(changed), .snapReq(snapReq), .snapValid(snapValid), .snapReady(snapReady),
    .snapData(snapData), .snapChanged(snapChanged), .snapDrop(snapDrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < CH; i++) begin
      mReg[i] = '0; mChg[i] = 1'b0; mSnap[i] = '0; mSnapCh[i] = 1'b0;
    end
    mValid = 1'b0;
    mDrop  = 1'b0;
  endtask

  // One rising edge: the model consumes the inputs present before the edge.
  task automatic tick();
    logic takeSnap;
    @(posedge clk);
    takeSnap = snapReq && (!mValid || snapReady);
    if (mValid && snapReq && !snapReady) mDrop = 1'b1;
    if (mValid && snapReady && !snapReq) mValid = 1'b0;
    if (takeSnap) begin
      for (int i = 0; i < CH; i++) begin
        mSnap[i]   = mReg[i];
        mSnapCh[i] = mChg[i];
        mChg[i]    = 1'b0;
      end
      mValid = 1'b1;
    end
    for (int i = 0; i < CH; i++) begin
      if (crit[i]) begin
        if (dataIn[i*W +: W] != mReg[i]) mChg[i] = 1'b1;
        mReg[i] = dataIn[i*W +: W];
      end
    end
    #1;
  endtask

  function automatic logic [CH*W-1:0] expDataOut();
    logic [CH*W-1:0] r;
    for (int i = 0; i < CH; i++) begin
`ifdef LATCH_BANK_TRANSPARENT_EN
      r[i*W +: W] = crit[i] ? dataIn[i*W +: W] : mReg[i];
`else
      r[i*W +: W] = mReg[i];
`endif
    end
    return r;
  endfunction

  function automatic logic [CH*W-1:0] expSnapData();
    logic [CH*W-1:0] r;
    for (int i = 0; i < CH; i++) r[i*W +: W] = mSnap[i];
    return r;
  endfunction

  function automatic logic [CH-1:0] expChanged();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = mChg[i];
    return r;
  endfunction

  function automatic logic [CH-1:0] expSnapChanged();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = mSnapCh[i];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; crit = '0; dataIn = '0; snapReq = 1'b0; snapReady = 1'b0;
    modelReset();
    #12;
    checks++;
    if (dataOut !== '0 || changed !== '0 || snapValid !== 1'b0 || snapDrop !== 1'b0 ||
        snapData !== '0 || snapChanged !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: dataOut=%h changed=%b valid=%b drop=%b snapData=%h snapCh=%b expected all 0",
               dataOut, changed, snapValid, snapDrop, snapData, snapChanged);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dataIn = {CH{8'hA5}};
    repeat (3) tick();
    checks++;
    if (dataOut !== '0 || changed !== 4'b0000 || snapValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_after_reset: dataOut=%h changed=%b valid=%b expected 0/0000/0",
               dataOut, changed, snapValid);
    end
  endtask

  task automatic test_load();
    crit = 4'b0101;
    dataIn = {8'hEE, 8'h33, 8'hDD, 8'h11};
    tick();
    crit = '0;
    #1;
    checks++;
    if (dataOut !== 32'h0033_0011) begin
      errors++;
      $display("[TB] FAIL load_data: got %h expected %h", dataOut, 32'h0033_0011);
    end
    checks++;
    if (changed !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL load_changed: got %b expected 0101", changed);
    end
    crit = 4'b0001;
    dataIn = 32'h0000_0011;
    tick();
    crit = '0;
    checks++;
    if (changed !== 4'b0101 || dataOut !== expDataOut()) begin
      errors++;
      $display("[TB] FAIL reload_same: changed=%b dataOut=%h expected 0101 %h", changed, dataOut, expDataOut());
    end
  endtask

  task automatic test_snapshot_backpressure();
    snapReq = 1'b1; snapReady = 1'b0;
    tick();
    snapReq = 1'b0;
    checks++;
    if (snapValid !== 1'b1 || snapData !== 32'h0033_0011 || snapChanged !== 4'b0101 || changed !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL snap_capture: valid=%b data=%h snapCh=%b changed=%b expected 1 00330011 0101 0000",
               snapValid, snapData, snapChanged, changed);
    end
    for (int c = 0; c < 4; c++) begin
      dataIn = $urandom;
      crit = 4'(c + 1);
      tick();
      checks++;
      if (snapValid !== 1'b1 || snapData !== 32'h0033_0011 || snapChanged !== 4'b0101) begin
        errors++;
        $display("[TB] FAIL snap_stable: valid=%b data=%h snapCh=%b expected 1 00330011 0101",
                 snapValid, snapData, snapChanged);
      end
    end
    crit = '0;
    snapReady = 1'b1;
    tick();
    snapReady = 1'b0;
    checks++;
    if (snapValid !== 1'b0 || changed !== expChanged() || dataOut !== expDataOut()) begin
      errors++;
      $display("[TB] FAIL snap_accept: valid=%b changed=%b dataOut=%h expected 0 %b %h",
               snapValid, changed, dataOut, expChanged(), expDataOut());
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] oldCh1;
    oldCh1 = mReg[1];
    // Clear pending flags first so the set-wins effect on ch1 is isolated
    snapReq = 1'b1; tick(); snapReq = 1'b0;
    snapReady = 1'b1; tick(); snapReady = 1'b0;
    crit = 4'b0010;
    dataIn = {8'h00, 8'h00, 8'h7E, 8'h00};
    if (oldCh1 == 8'h7E) dataIn[15:8] = 8'h7F;
    snapReq = 1'b1;
    tick();
    snapReq = 1'b0; crit = '0;
    checks++;
    if (snapData[15:8] !== oldCh1 || snapChanged[1] !== 1'b0 || changed[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_wins: snapCh1=%h snapChanged1=%b changed1=%b expected %h 0 1",
               snapData[15:8], snapChanged[1], changed[1], oldCh1);
    end
    snapReady = 1'b1; tick(); snapReady = 1'b0;
  endtask

  task automatic test_drop_back_to_back();
    logic [CH*W-1:0] held;
    snapReq = 1'b1; tick();
    held = expSnapData();
    crit = 4'b0100; dataIn = 32'h0044_0000;
    snapReq = 1'b1; snapReady = 1'b0;
    tick();
    crit = '0;
    checks++;
    if (snapDrop !== 1'b1 || snapValid !== 1'b1 || snapData !== held) begin
      errors++;
      $display("[TB] FAIL drop: drop=%b valid=%b data=%h expected 1 1 %h", snapDrop, snapValid, snapData, held);
    end
    snapReq = 1'b1; snapReady = 1'b1;
    tick();
    snapReq = 1'b0; snapReady = 1'b0;
    checks++;
    if (snapValid !== 1'b1 || snapData[23:16] !== 8'h44 || snapData !== expSnapData() ||
        snapChanged !== expSnapChanged()) begin
      errors++;
      $display("[TB] FAIL back_to_back: valid=%b data=%h snapCh=%b expected 1 %h %b",
               snapValid, snapData, snapChanged, expSnapData(), expSnapChanged());
    end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      crit = 4'($urandom);
      for (int i = 0; i < CH; i++) dataIn[i*W +: W] = 8'($urandom_range(0, 3));
      snapReq   = ($urandom_range(0, 9) < 3);
      snapReady = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if (dataOut !== expDataOut()) begin
        errors++; $display("[TB] FAIL rnd_dataOut: got %h expected %h", dataOut, expDataOut());
      end
      checks++;
      if (changed !== expChanged()) begin
        errors++; $display("[TB] FAIL rnd_changed: got %b expected %b", changed, expChanged());
      end
      checks++;
      if (snapValid !== mValid) begin
        errors++; $display("[TB] FAIL rnd_snapValid: got %b expected %b", snapValid, mValid);
      end
      checks++;
      if (snapData !== expSnapData() || snapChanged !== expSnapChanged()) begin
        errors++;
        $display("[TB] FAIL rnd_snapshot: got %h/%b expected %h/%b", snapData, snapChanged,
                 expSnapData(), expSnapChanged());
      end
      checks++;
      if (snapDrop !== mDrop) begin
        errors++; $display("[TB] FAIL rnd_snapDrop: got %b expected %b", snapDrop, mDrop);
      end
    end
    snapReq = 1'b0; snapReady = 1'b0; crit = '0;
  endtask

  task automatic test_async_reset();
    logic [CH*W-1:0] want;
    crit = 4'b1111; dataIn = 32'h1234_5678; snapReq = 1'b1;
    tick();
    snapReq = 1'b0; crit = 4'b1000; dataIn = 32'h5A00_0000;
    checks++;
    if (snapValid !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_async_valid: got %b expected 1", snapValid);
    end
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
`ifdef LATCH_BANK_TRANSPARENT_EN
    want = 32'h5A00_0000;
`else
    want = '0;
`endif
    checks++;
    if (snapValid !== 1'b0 || dataOut !== want || changed !== '0 || snapDrop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b dataOut=%h changed=%b drop=%b expected 0 %h 0000 0",
               snapValid, dataOut, changed, snapDrop, want);
    end
    crit = '0; dataIn = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_load();
    test_snapshot_backpressure();
    test_collision();
    test_drop_back_to_back();
    test_random(300);
    test_async_reset();
    test_random(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
